sevenseg_display_bank: RTL and testbench
========================================

# sevenseg_display_bank

Parametrised N-digit seven-segment display driver for the board HEX displays. It accepts a packed value on a one-cycle load strobe and shows it either as raw hex nibbles or as unsigned decimal. Decimal conversion uses an iterative shift-add-3 (double-dabble) engine. The block adds leading-zero suppression, overflow indication, per-digit blink and selectable segment polarity, and sits between the I/O-port registers and the HEX pins.

## Interface
- N_DIGITS, 4, number of digits driven; legal range 1..8; W = 4*N_DIGITS.
- ACTIVE_LOW, 1, 1 = common-anode (segment on = 0), 0 = segment on = 1.
- BLINK_DIV, 24, prescaler width in bits; blink phase = prescaler MSB; legal range ≥ 2.
- clock  in  1  single clock; all state on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- load  in  1  capture request; honoured only when busy = 0.
- value  in  W  hex nibbles (digit i = value[4i+3:4i]) or unsigned binary in decimal mode.
- dec_mode  in  1  sampled with load; 1 = decimal, 0 = hex.
- lz_suppress  in  1  sampled with load; 1 = blank leading zeros.
- blink_mask  in  N_DIGITS  live (not sampled); bit i = digit i blinks.
- busy  out  1  high while a capture is in progress.
- segs  out  7*N_DIGITS  registered; digit i = segs[7i+6:7i], bit order g f e d c b a (bit 6 = g).

## Operation
- FSM states: IDLE, CONVERT, COMMIT.
  - IDLE + load: capture value, dec_mode and lz_suppress.
    - Hex: go to COMMIT.
    - Decimal: clear BCD register and overflow flag, load shift counter = W, go to CONVERT.
  - CONVERT: each cycle, add 3 to every BCD digit ≥ 5, then shift the binary MSB into the BCD LSB and decrement the counter. Go to COMMIT after W shifts.
  - COMMIT: write digit registers, blank mask and overflow flag, then go to IDLE.
- Overflow: the BCD register holds exactly N_DIGITS digits. A 1 shifted out of the top digit sets a sticky overflow flag, which means value ≥ 10^N_DIGITS. Overflow is possible only in decimal mode.
- Leading-zero suppression: digits above the most significant nonzero digit are blanked. Digit 0 is never suppressed, so a value of 0 shows "0". Suppression applies in both modes.
- Segment encoding (active-high, gfe_dcba):
  - 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
  - 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
  - blank = 00, dash = 40
  - When ACTIVE_LOW = 1, every pattern is bitwise inverted.
- Per-digit output priority: overflow → dash on all digits; else suppressed → blank; else blink_mask[i] and phase = 1 → blank; else the digit glyph.
- Prescaler: free-running BLINK_DIV-bit up-counter, wraps to 0. Phase = MSB, so the phase toggles every 2^(BLINK_DIV-1) cycles.
- load while busy = 1 is ignored entirely and is not queued.
- The displayed value persists until the next COMMIT.

## Timing
- Reset (async assert): state = IDLE, busy = 0, prescaler = 0, digit registers = 0, overflow = 0, blank mask all set. segs = all blank, i.e. all ones when ACTIVE_LOW = 1. Reset deasserts synchronously to the clock.
- Edge E0 is the edge at which load is sampled high in IDLE.
- Hex mode:
  - busy = 1 after E0.
  - COMMIT writes at E1; busy = 0 after E1.
  - segs show the new value after E2, so latency is 2 cycles.
- Decimal mode:
  - Shifts occur at E1..EW.
  - COMMIT writes at E(W+1); busy = 0 after E(W+1).
  - segs show the new value after E(W+2), so latency is W+2 cycles (18 for N_DIGITS = 4).
- A load can be accepted on the first edge where busy = 0 (back-to-back).
- segs re-registers every cycle, so a blink_mask change appears one cycle later.
- Reset asserted mid-CONVERT or mid-COMMIT aborts the capture; the output returns to the reset (blank) state.

## Test plan
- Hex: N_DIGITS = 4, ACTIVE_LOW = 0, load value = 16'hA1F3, dec_mode = 0, lz = 0 → 2 cycles later segs = {77, 06, 71, 4F}; busy high exactly 1 cycle.
- Decimal: value = 16'h04D2 (1234), dec_mode = 1 → busy high 17 cycles; segs = {06, 5B, 4F, 66} at cycle 18. Repeat with lz = 1, value = 42 → {00, 00, 66, 5B}. Repeat with value = 0 → {00, 00, 00, 3F}.
- Overflow: value = 16'h2710 (10000), dec_mode = 1 → all digits = 40. Then value = 9999 → {6F, 6F, 6F, 6F}, overflow cleared.
- Blink: BLINK_DIV = 4, blink_mask = 4'b0001, value = 16'h1234 hex → digit 0 alternates between 66 and 00 every 8 cycles; other digits are steady.
- Busy/abort: load 1234 decimal, pulse load with value 5678 at cycle 5 → 1234 is displayed and 5678 is ignored. New load at cycle 6, assert resetn low at cycle 10 → segs = 7F per digit (ACTIVE_LOW = 1), busy = 0.

Source files
------------

// File: rtl/sevenseg_display_bank.sv
// N-digit seven-segment driver: captures a packed value on load and shows it as hex
// nibbles or as unsigned decimal (double-dabble), with zero blanking, overflow dashes and blink.
module sevenseg_display_bank #(
  parameter int N_DIGITS   = 4,
  parameter int ACTIVE_LOW = 1,
  parameter int BLINK_DIV  = 24
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   value,
  input  logic                    dec_mode,
  input  logic                    lz_suppress,
  input  logic [N_DIGITS-1:0]     blink_mask,
  output logic                    busy,
  output logic [7*N_DIGITS-1:0]   segs,
  output logic [1:0]              state_dbg
);

  localparam int W  = 4 * N_DIGITS;
  localparam int CW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    COMMIT  = 2'd2
  } state_t;

  state_t               state, state_next;
  logic [W-1:0]         bin_q, bcd_q, bcd_adj, dig_src, dig_q;
  logic                 dec_q, lz_q, ovf_acc, ovf_q, seen_nz;
  logic [CW-1:0]        cnt_q;
  logic [N_DIGITS-1:0]  blank_q, blank_next;
  logic [BLINK_DIV-1:0] pre_q;
  logic [6:0]           pat;
  logic [7*N_DIGITS-1:0] segs_next;

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // State register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  // Next-state logic; load is only looked at in IDLE, so a busy load is simply dropped
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = dec_mode ? CONVERT : COMMIT;
      CONVERT: if (cnt_q == CW'(1)) state_next = COMMIT;
      COMMIT:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    busy      = (state != IDLE);
    state_dbg = state;
  end

  // Add-3 correction on every BCD digit before the shift
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (bcd_q[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
    end
  end

  assign dig_src = dec_q ? bcd_q : bin_q;

  // Leading-zero mask: blank every digit above the top nonzero one, never digit 0
  always_comb begin
    blank_next = '0;
    seen_nz    = 1'b0;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      seen_nz       = seen_nz | (dig_src[4*i +: 4] != 4'd0);
      blank_next[i] = lz_q & ~seen_nz;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      bin_q   <= '0;
      bcd_q   <= '0;
      dec_q   <= 1'b0;
      lz_q    <= 1'b0;
      ovf_acc <= 1'b0;
      cnt_q   <= '0;
      dig_q   <= '0;
      blank_q <= '1;
      ovf_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          bin_q   <= value;
          dec_q   <= dec_mode;
          lz_q    <= lz_suppress;
          bcd_q   <= '0;
          ovf_acc <= 1'b0;
          cnt_q   <= CW'(W);
        end
        CONVERT: begin
          // A carry out of the top digit means the value needs more digits than we have
          bcd_q   <= {bcd_adj[W-2:0], bin_q[W-1]};
          ovf_acc <= ovf_acc | bcd_adj[W-1];
          bin_q   <= bin_q << 1;
          cnt_q   <= cnt_q - CW'(1);
        end
        COMMIT: begin
          dig_q   <= dig_src;
          blank_q <= blank_next;
          ovf_q   <= dec_q & ovf_acc;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) pre_q <= '0;
    else         pre_q <= pre_q + BLINK_DIV'(1);
  end

  // Per-digit priority: overflow dash, suppressed blank, blink blank, glyph
  always_comb begin
    segs_next = '0;
    pat       = '0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (ovf_q)                                    pat = 7'h40;
      else if (blank_q[i])                          pat = 7'h00;
      else if (blink_mask[i] && pre_q[BLINK_DIV-1]) pat = 7'h00;
      else                                          pat = glyph(dig_q[4*i +: 4]);
      segs_next[7*i +: 7] = (ACTIVE_LOW != 0) ? ~pat : pat;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) segs <= (ACTIVE_LOW != 0) ? '1 : '0;
    else         segs <= segs_next;
  end

endmodule

// File: tb/tb_sevenseg_display_bank.sv
// Bench for sevenseg_display_bank: two instances (active-high and active-low segments)
// share stimulus; expected patterns are queued on load and compared when they appear.
module tb_sevenseg_display_bank;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        load = 1'b0;
  logic [15:0] value = '0;
  logic        dec_mode = 1'b0;
  logic        lz_suppress = 1'b0;
  logic [3:0]  blink_mask = '0;
  logic        busy_h, busy_l;
  logic [27:0] segs_h, segs_l;
  logic [1:0]  st_h, st_l;

  logic [27:0] exp_q[$];
  logic [27:0] last_exp;
  logic [3:0]  tb_pre;
  int          n_vec = 0;
  int          n_bad = 0;

  // Clock / reset
  always #5 clock = ~clock;

  always @(posedge clock or negedge resetn) begin
    if (!resetn) tb_pre <= '0;
    else         tb_pre <= tb_pre + 4'd1;
  end

  sevenseg_display_bank #(.N_DIGITS(4), .ACTIVE_LOW(0), .BLINK_DIV(4)) dut_h (
    .clock(clock), .resetn(resetn), .load(load), .value(value), .dec_mode(dec_mode),
    .lz_suppress(lz_suppress), .blink_mask(blink_mask), .busy(busy_h), .segs(segs_h),
    .state_dbg(st_h)
  );

  sevenseg_display_bank #(.N_DIGITS(4), .ACTIVE_LOW(1), .BLINK_DIV(4)) dut_l (
    .clock(clock), .resetn(resetn), .load(load), .value(value), .dec_mode(dec_mode),
    .lz_suppress(lz_suppress), .blink_mask(blink_mask), .busy(busy_l), .segs(segs_l),
    .state_dbg(st_l)
  );

  function automatic logic [6:0] glyph(input logic [3:0] d);
    case (d)
      4'h0: glyph = 7'h3F;  4'h1: glyph = 7'h06;  4'h2: glyph = 7'h5B;  4'h3: glyph = 7'h4F;
      4'h4: glyph = 7'h66;  4'h5: glyph = 7'h6D;  4'h6: glyph = 7'h7D;  4'h7: glyph = 7'h07;
      4'h8: glyph = 7'h7F;  4'h9: glyph = 7'h6F;  4'hA: glyph = 7'h77;  4'hB: glyph = 7'h7C;
      4'hC: glyph = 7'h39;  4'hD: glyph = 7'h5E;  4'hE: glyph = 7'h79;  default: glyph = 7'h71;
    endcase
  endfunction

  // Reference model using integer division for the decimal digits
  function automatic logic [27:0] model(input logic [15:0] v, input bit dec, input bit lz,
                                        input logic [3:0] mask, input bit ph);
    logic [3:0]  d[4];
    logic [27:0] r;
    int          x;
    int          top;
    bit          ovf;
    x   = int'(v);
    ovf = dec && (x >= 10000);
    top = 0;
    r   = '0;
    for (int i = 0; i < 4; i++) begin
      if (dec) begin
        d[i] = 4'(x % 10);
        x    = x / 10;
      end else begin
        d[i] = v[4*i +: 4];
      end
    end
    for (int i = 0; i < 4; i++) if (d[i] != 4'd0) top = i;
    for (int i = 0; i < 4; i++) begin
      if (ovf)                 r[7*i +: 7] = 7'h40;
      else if (lz && i > top)  r[7*i +: 7] = 7'h00;
      else if (mask[i] && ph)  r[7*i +: 7] = 7'h00;
      else                     r[7*i +: 7] = glyph(d[i]);
    end
    return r;
  endfunction

  // Driver: issue one load, count busy cycles, return segs just before and after the update
  task automatic run_load(input logic [15:0] v, input bit dec, input bit lz,
                          output int bcyc, output logic [27:0] prior,
                          output logic [27:0] gh, output logic [27:0] gl);
    @(negedge clock);
    value = v; dec_mode = dec; lz_suppress = lz; load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    bcyc = 0;
    while (busy_h && bcyc < 100) begin
      bcyc++;
      @(negedge clock);
    end
    prior = segs_h;
    @(negedge clock);
    gh = segs_h;
    gl = segs_l;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    n_vec++;
    if ({busy_h, busy_l} !== 2'b00) begin
      n_bad++; $display("FAIL reset_busy got %b%b want 00", busy_h, busy_l);
    end
    n_vec++;
    if ({segs_h, segs_l} !== {28'h0000000, 28'hFFFFFFF}) begin
      n_bad++; $display("FAIL reset_segs got %h/%h want 0000000/fffffff", segs_h, segs_l);
    end
    n_vec++;
    if ({st_h, st_l} !== 4'b0000) begin
      n_bad++; $display("FAIL reset_state got %0d/%0d want 0/0", st_h, st_l);
    end
    resetn = 1'b1;
    @(negedge clock);
    n_vec++;
    if ({segs_h, segs_l, busy_h} !== {28'h0000000, 28'hFFFFFFF, 1'b0}) begin
      n_bad++; $display("FAIL reset_release got %h/%h busy %b want blank, idle", segs_h, segs_l, busy_h);
    end
    last_exp = 28'h0000000;
  endtask

  task automatic test_hex();
    int          bc;
    logic [27:0] pr, gh, gl, e;
    exp_q.push_back({7'h77, 7'h06, 7'h71, 7'h4F});
    run_load(16'hA1F3, 1'b0, 1'b0, bc, pr, gh, gl);
    n_vec++;
    if (bc !== 1) begin n_bad++; $display("FAIL hex_busy_cycles got %0d want 1", bc); end
    n_vec++;
    if (pr !== last_exp) begin n_bad++; $display("FAIL hex_persist got %h want %h", pr, last_exp); end
    e = exp_q.pop_front();
    n_vec++;
    if ({gh, gl} !== {e, ~e}) begin
      n_bad++; $display("FAIL hex_a1f3 got %h/%h want %h/%h", gh, gl, e, ~e);
    end
    last_exp = e;
    // hex with zero blanking: 00A0 shows "  A0"
    exp_q.push_back(model(16'h00A0, 1'b0, 1'b1, 4'b0, 1'b0));
    run_load(16'h00A0, 1'b0, 1'b1, bc, pr, gh, gl);
    e = exp_q.pop_front();
    n_vec++;
    if ({gh, gl} !== {e, ~e}) begin
      n_bad++; $display("FAIL hex_lz_00a0 got %h/%h want %h/%h", gh, gl, e, ~e);
    end
    last_exp = e;
  endtask

  task automatic test_decimal();
    int          bc;
    logic [27:0] pr, gh, gl, e;
    exp_q.push_back({7'h06, 7'h5B, 7'h4F, 7'h66});
    run_load(16'h04D2, 1'b1, 1'b0, bc, pr, gh, gl);
    n_vec++;
    if (bc !== 17) begin n_bad++; $display("FAIL dec_busy_cycles got %0d want 17", bc); end
    n_vec++;
    if (pr !== last_exp) begin n_bad++; $display("FAIL dec_persist got %h want %h", pr, last_exp); end
    e = exp_q.pop_front();
    n_vec++;
    if ({gh, gl} !== {e, ~e}) begin
      n_bad++; $display("FAIL dec_1234 got %h/%h want %h/%h", gh, gl, e, ~e);
    end
    exp_q.push_back({7'h00, 7'h00, 7'h66, 7'h5B});
    run_load(16'd42, 1'b1, 1'b1, bc, pr, gh, gl);
    e = exp_q.pop_front();
    n_vec++;
    if ({gh, gl} !== {e, ~e}) begin
      n_bad++; $display("FAIL dec_lz_42 got %h/%h want %h/%h", gh, gl, e, ~e);
    end
    exp_q.push_back({7'h00, 7'h00, 7'h00, 7'h3F});
    run_load(16'd0, 1'b1, 1'b1, bc, pr, gh, gl);
    e = exp_q.pop_front();
    n_vec++;
    if ({gh, gl} !== {e, ~e}) begin
      n_bad++; $display("FAIL dec_lz_0 got %h/%h want %h/%h", gh, gl, e, ~e);
    end
    // a few random decimal values below the overflow threshold
    for (int k = 0; k < 4; k++) begin
      logic [15:0] rv;
      rv = 16'($urandom_range(0, 9999));
      exp_q.push_back(model(rv, 1'b1, k[0], 4'b0, 1'b0));
      run_load(rv, 1'b1, k[0], bc, pr, gh, gl);
      e = exp_q.pop_front();
      n_vec++;
      if ({gh, gl} !== {e, ~e}) begin
        n_bad++; $display("FAIL dec_rand_%0d got %h/%h want %h/%h", rv, gh, gl, e, ~e);
      end
    end
  endtask

  task automatic test_overflow();
    int          bc;
    logic [27:0] pr, gh, gl, e;
    logic [15:0] vals[3];
    vals[0] = 16'd10000;
    vals[1] = 16'd9999;
    vals[2] = 16'hFFFF;
    for (int k = 0; k < 3; k++) begin
      if (k == 1) exp_q.push_back({7'h6F, 7'h6F, 7'h6F, 7'h6F});
      else        exp_q.push_back({7'h40, 7'h40, 7'h40, 7'h40});
      run_load(vals[k], 1'b1, 1'b0, bc, pr, gh, gl);
      e = exp_q.pop_front();
      n_vec++;
      if ({gh, gl} !== {e, ~e}) begin
        n_bad++; $display("FAIL ovf_%0d got %h/%h want %h/%h", vals[k], gh, gl, e, ~e);
      end
    end
  endtask

  task automatic test_blink();
    int          bc;
    logic [27:0] pr, gh, gl, e;
    run_load(16'h1234, 1'b0, 1'b0, bc, pr, gh, gl);
    @(negedge clock);
    blink_mask = 4'b0001;
    for (int k = 0; k < 24; k++) begin
      exp_q.push_back(model(16'h1234, 1'b0, 1'b0, blink_mask, tb_pre[3]));
      @(negedge clock);
      e = exp_q.pop_front();
      n_vec++;
      if ({segs_h, segs_l} !== {e, ~e}) begin
        n_bad++; $display("FAIL blink_cyc%0d got %h/%h want %h/%h", k, segs_h, segs_l, e, ~e);
      end
    end
    blink_mask = 4'b0000;
    exp_q.push_back(model(16'h1234, 1'b0, 1'b0, 4'b0, 1'b0));
    @(negedge clock);
    e = exp_q.pop_front();
    n_vec++;
    if ({segs_h, segs_l} !== {e, ~e}) begin
      n_bad++; $display("FAIL blink_off got %h/%h want %h/%h", segs_h, segs_l, e, ~e);
    end
  endtask

  task automatic test_back_to_back();
    logic [27:0] e;
    @(negedge clock);
    value = 16'h0123; dec_mode = 1'b0; lz_suppress = 1'b0; load = 1'b1;
    exp_q.push_back(model(16'h0123, 1'b0, 1'b0, 4'b0, 1'b0));
    @(negedge clock);
    value = 16'hBEEF;  // load held high while the first capture commits
    n_vec++;
    if (busy_h !== 1'b1) begin n_bad++; $display("FAIL b2b_busy got %b want 1", busy_h); end
    @(negedge clock);
    n_vec++;
    if (busy_h !== 1'b0) begin n_bad++; $display("FAIL b2b_free got %b want 0", busy_h); end
    exp_q.push_back({7'h7C, 7'h79, 7'h79, 7'h71});
    @(negedge clock);
    load = 1'b0;
    n_vec++;
    if (busy_h !== 1'b1) begin n_bad++; $display("FAIL b2b_accept got %b want 1", busy_h); end
    e = exp_q.pop_front();
    n_vec++;
    if ({segs_h, segs_l} !== {e, ~e}) begin
      n_bad++; $display("FAIL b2b_first got %h/%h want %h/%h", segs_h, segs_l, e, ~e);
    end
    @(negedge clock);
    @(negedge clock);
    e = exp_q.pop_front();
    n_vec++;
    if ({segs_h, segs_l} !== {e, ~e}) begin
      n_bad++; $display("FAIL b2b_second got %h/%h want %h/%h", segs_h, segs_l, e, ~e);
    end
  endtask

  task automatic test_busy_abort();
    int          n;
    logic [27:0] e;
    @(negedge clock);
    value = 16'd1234; dec_mode = 1'b1; lz_suppress = 1'b0; load = 1'b1;
    exp_q.push_back({7'h06, 7'h5B, 7'h4F, 7'h66});
    @(negedge clock);
    load = 1'b0;
    repeat (3) @(negedge clock);
    value = 16'd5678; load = 1'b1;   // arrives mid-conversion and must be dropped
    @(negedge clock);
    load = 1'b0;
    n = 0;
    while (busy_h && n < 100) begin
      n++;
      @(negedge clock);
    end
    @(negedge clock);
    e = exp_q.pop_front();
    n_vec++;
    if ({segs_h, segs_l} !== {e, ~e}) begin
      n_bad++; $display("FAIL busy_ignore got %h/%h want %h/%h", segs_h, segs_l, e, ~e);
    end
    n_vec++;
    if (busy_h !== 1'b0) begin n_bad++; $display("FAIL busy_not_queued got %b want 0", busy_h); end
    @(negedge clock);
    value = 16'd5678; load = 1'b1;
    exp_q.push_back(model(16'd5678, 1'b1, 1'b0, 4'b0, 1'b0));
    @(negedge clock);
    load = 1'b0;
    repeat (3) @(negedge clock);
    #2 resetn = 1'b0;
    #1;
    exp_q.delete();
    n_vec++;
    if ({busy_h, busy_l, st_h} !== 4'b0000) begin
      n_bad++; $display("FAIL abort_busy got %b/%b state %0d want 0/0 state 0", busy_h, busy_l, st_h);
    end
    n_vec++;
    if ({segs_h, segs_l} !== {28'h0000000, 28'hFFFFFFF}) begin
      n_bad++; $display("FAIL abort_segs got %h/%h want 0000000/fffffff", segs_h, segs_l);
    end
    @(negedge clock);
    resetn = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++;
    if ({segs_h, segs_l, busy_h} !== {28'h0000000, 28'hFFFFFFF, 1'b0}) begin
      n_bad++; $display("FAIL abort_after got %h/%h busy %b want blank, idle", segs_h, segs_l, busy_h);
    end
  endtask

  initial begin
    test_reset();
    test_hex();
    test_decimal();
    test_overflow();
    test_blink();
    test_back_to_back();
    test_busy_abort();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired after %0t", $time);
    $fatal(1);
  end

endmodule
